mem_controller_ncores_pipelined: RTL and testbench

//  Arbitrates batched data-memory accesses from N_CORES lanes onto one single-port synchronous data memory.
//  - One batch = one m_read or m_write start pulse; all enabled lanes are served in lowest-index-first order.
//  - Successor to the N-core memory controller:
//    - parametrised widths, lane count and memory read latency;
//    - pipelined issue at one access per cycle;
//    - optional read-address coalescing.
//  - Sits between the core array and the data memory.

---
 rtl/mem_controller_ncores_pipelined.sv | 194 +++++++++++++++++++
 tb/tb_mem_controller_ncores_pipelined.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller_ncores_pipelined.sv
// rtl/mem_controller_ncores_pipelined.sv - batched N-lane arbiter onto one single-port data memory
module mem_controller_ncores_pipelined #(
    parameter int N_CORES    = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_RD_LAT = 1,
    parameter int COALESCE   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        m_read,
    input  logic                        m_write,
    output logic                        m_ready,
    input  logic [N_CORES-1:0]          en,
    input  logic [N_CORES*ADDR_W-1:0]   addr,
    input  logic [N_CORES*DATA_W-1:0]   wdata,
    output logic [N_CORES*DATA_W-1:0]   rdata,
    output logic [N_CORES-1:0]          rvalid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int LANE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_CORES-1:0]  r_pending;
    logic [N_CORES-1:0]  w_pending_nxt;
    logic [N_CORES-1:0]  w_served;
    logic [N_CORES-1:0]  r_rvalid;
    logic [ADDR_W-1:0]   r_addr  [N_CORES];
    logic [DATA_W-1:0]   r_wdata [N_CORES];
    logic [DATA_W-1:0]   r_rdata [N_CORES];
    logic                r_is_write;
    // served-lane masks of reads in flight; stage MEM_RD_LAT-1 is the one whose data is on mem_rdata
    logic [N_CORES-1:0]  r_pipe  [MEM_RD_LAT];
    logic [LANE_W-1:0]   w_cur;
    logic                w_start;
    logic                w_read_empty;
    logic                w_pipe_busy;
    logic [N_CORES-1:0]  w_emerge;

    assign w_start      = (r_state == S_IDLE) && (m_read ^ m_write) && (en != '0);
    assign w_read_empty = (r_state == S_IDLE) && m_read && !m_write && (en == '0);
    assign w_emerge     = r_pipe[MEM_RD_LAT-1];

    // lowest-index pending lane is the one served this cycle
    always_comb begin
        w_cur = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_cur = LANE_W'(i);
            end
        end
    end

    // lanes retired by this access; coalescing reads also retire equal-address lanes
    always_comb begin
        w_served        = '0;
        w_served[w_cur] = 1'b1;
        if (COALESCE != 0 && !r_is_write) begin
            for (int i = 0; i < N_CORES; i++) begin
                if (r_pending[i] && (r_addr[i] == r_addr[w_cur])) begin
                    w_served[i] = 1'b1;
                end
            end
        end
    end

    // reads still in flight beyond the stage that returns data this cycle
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int k = 0; k < MEM_RD_LAT - 1; k++) begin
            w_pipe_busy = w_pipe_busy | (|r_pipe[k]);
        end
    end

    // next-state, pending update and memory-side outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        m_ready       = 1'b0;
        mem_wren      = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                m_ready = 1'b1;
                if (w_start) begin
                    w_state_nxt   = S_ISSUE;
                    w_pending_nxt = en;
                end
            end
            S_ISSUE: begin
                mem_wren      = r_is_write;
                mem_addr      = r_addr[w_cur];
                mem_wdata     = r_wdata[w_cur];
                w_pending_nxt = r_pending & ~w_served;
                if (w_pending_nxt == '0) begin
                    w_state_nxt = r_is_write ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // state and pending-lane register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // batch operands captured at the accepted start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_write <= 1'b0;
            for (int i = 0; i < N_CORES; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
            end
        end else if (w_start) begin
            r_is_write <= m_write;
            for (int i = 0; i < N_CORES; i++) begin
                r_addr[i]  <= addr[i*ADDR_W +: ADDR_W];
                r_wdata[i] <= wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // read-return pipeline aligned with the memory read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MEM_RD_LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= (r_state == S_ISSUE && !r_is_write) ? w_served : '0;
            for (int k = 1; k < MEM_RD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // lane results: cleared by a new read/write start, filled as masks emerge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                r_rdata[i] <= '0;
            end
        end else if (w_start || w_read_empty) begin
            r_rvalid <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (w_emerge[i]) begin
                    r_rdata[i]  <= mem_rdata;
                    r_rvalid[i] <= 1'b1;
                end
            end
        end
    end

    // flatten lane results onto the output bus
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            rdata[i*DATA_W +: DATA_W] = r_rdata[i];
        end
    end

    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_mem_controller_ncores_pipelined.sv
// tb/tb_mem_controller_ncores_pipelined.sv - randomized self-checking bench for three controller configurations
module tb_mem_controller_ncores_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_read;
    logic        m_write;
    logic        mem_init;
    logic [3:0]  en;
    logic [63:0] addr;
    logic [63:0] wdata;

    logic        m_ready_g    [3];
    logic [63:0] rdata_g      [3];
    logic [3:0]  rvalid_g     [3];
    logic [15:0] mem_addr_g   [3];
    logic [15:0] mem_wdata_g  [3];
    logic [15:0] mem_rdata_g  [3];
    logic        mem_wren_g   [3];

    logic [15:0] ref_mem   [256];
    logic [15:0] exp_rdata [4];
    logic [3:0]  exp_rvalid;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 97 + 13) & 16'hFFFF);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic logic [15:0] lane(input logic [63:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    // g=0: LAT1 no coalesce, g=1: LAT1 coalesce, g=2: LAT3 no coalesce
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int LAT  = (g == 2) ? 3 : 1;
        localparam int COAL = (g == 1) ? 1 : 0;
        logic [15:0] mem     [256];
        logic [15:0] rd_pipe [3];

        mem_controller_ncores_pipelined #(
            .N_CORES(4), .ADDR_W(16), .DATA_W(16), .MEM_RD_LAT(LAT), .COALESCE(COAL)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m_read    (m_read),
            .m_write   (m_write),
            .m_ready   (m_ready_g[g]),
            .en        (en),
            .addr      (addr),
            .wdata     (wdata),
            .rdata     (rdata_g[g]),
            .rvalid    (rvalid_g[g]),
            .mem_addr  (mem_addr_g[g]),
            .mem_wdata (mem_wdata_g[g]),
            .mem_wren  (mem_wren_g[g]),
            .mem_rdata (mem_rdata_g[g])
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
            end else if (mem_wren_g[g]) begin
                mem[mem_addr_g[g][7:0]] <= mem_wdata_g[g];
            end
            rd_pipe[0] <= mem[mem_addr_g[g][7:0]];
            rd_pipe[1] <= rd_pipe[0];
            rd_pipe[2] <= rd_pipe[1];
        end
        assign mem_rdata_g[g] = rd_pipe[LAT-1];
    end

    task automatic check_idle_outputs(input string name);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (m_ready_g[g] !== 1'b1) begin errors++; $display("FAIL %s g%0d m_ready: got %b want 1", name, g, m_ready_g[g]); end
            checks++;
            if (mem_wren_g[g] !== 1'b0) begin errors++; $display("FAIL %s g%0d mem_wren: got %b want 0", name, g, mem_wren_g[g]); end
            checks++;
            if (mem_addr_g[g] !== 16'd0 || mem_wdata_g[g] !== 16'd0) begin
                errors++; $display("FAIL %s g%0d mem_addr/wdata: got %0d/%0d want 0/0", name, g, mem_addr_g[g], mem_wdata_g[g]);
            end
            checks++;
            if (rvalid_g[g] !== 4'b0 || rdata_g[g] !== 64'd0) begin
                errors++; $display("FAIL %s g%0d rvalid/rdata: got %b/%h want 0/0", name, g, rvalid_g[g], rdata_g[g]);
            end
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic run_batch(input logic rd, input logic wr, input logic [3:0] b_en,
                             input logic [63:0] b_addr, input logic [63:0] b_wd,
                             input bit pulse_busy, input string name);
        int          k[3];
        int          exp_busy[3];
        int          busy[3];
        logic [15:0] sq_a[3][4];
        logic [15:0] sq_w[3][4];
        logic [15:0] a;
        bit          op_ok;
        bit          dup;
        int          maxb;
        op_ok = (rd ^ wr) && (b_en != 4'b0);
        maxb  = 0;
        for (int g = 0; g < 3; g++) begin
            k[g] = 0;
            busy[g] = 0;
            for (int i = 0; i < 4; i++) begin
                if (b_en[i]) begin
                    dup = 1'b0;
                    if (rd && g == 1) begin
                        for (int j = 0; j < k[g]; j++) if (sq_a[g][j] == lane(b_addr, i)) dup = 1'b1;
                    end
                    if (!dup) begin
                        sq_a[g][k[g]] = lane(b_addr, i);
                        sq_w[g][k[g]] = lane(b_wd, i);
                        k[g]++;
                    end
                end
            end
            if (!op_ok) k[g] = 0;
            exp_busy[g] = !op_ok ? 0 : (wr ? k[g] : k[g] + lat_of(g));
            if (exp_busy[g] > maxb) maxb = exp_busy[g];
        end
        if (rd && !wr) begin
            exp_rvalid = b_en;
            for (int i = 0; i < 4; i++) begin
                a = lane(b_addr, i);
                if (b_en[i]) exp_rdata[i] = ref_mem[a[7:0]];
            end
        end else if (wr && !rd && b_en != 4'b0) begin
            exp_rvalid = 4'b0;
            for (int i = 0; i < 4; i++) begin
                a = lane(b_addr, i);
                if (b_en[i]) ref_mem[a[7:0]] = lane(b_wd, i);
            end
        end

        @(negedge clk);
        m_read = rd; m_write = wr; en = b_en; addr = b_addr; wdata = b_wd;
        @(negedge clk);
        m_read = 1'b0; m_write = 1'b0;
        for (int c = 0; c < maxb + 2; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (!m_ready_g[g]) busy[g]++;
                if (c < k[g]) begin
                    checks++;
                    if (mem_addr_g[g] !== sq_a[g][c]) begin
                        errors++; $display("FAIL %s g%0d cyc%0d mem_addr: got %0d want %0d", name, g, c, mem_addr_g[g], sq_a[g][c]);
                    end
                    checks++;
                    if (mem_wren_g[g] !== wr) begin
                        errors++; $display("FAIL %s g%0d cyc%0d mem_wren: got %b want %b", name, g, c, mem_wren_g[g], wr);
                    end
                    if (wr) begin
                        checks++;
                        if (mem_wdata_g[g] !== sq_w[g][c]) begin
                            errors++; $display("FAIL %s g%0d cyc%0d mem_wdata: got %0d want %0d", name, g, c, mem_wdata_g[g], sq_w[g][c]);
                        end
                    end
                end else begin
                    checks++;
                    if (mem_wren_g[g] !== 1'b0) begin
                        errors++; $display("FAIL %s g%0d cyc%0d mem_wren: got %b want 0", name, g, c, mem_wren_g[g]);
                    end
                end
            end
            if (pulse_busy && c == 1) begin
                m_read = rd; m_write = wr; en = 4'hF;
            end
            if (pulse_busy && c == 2) begin
                m_read = 1'b0; m_write = 1'b0;
            end
            @(negedge clk);
        end
        m_read = 1'b0; m_write = 1'b0;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (busy[g] != exp_busy[g]) begin
                errors++; $display("FAIL %s g%0d busy_cycles: got %0d want %0d", name, g, busy[g], exp_busy[g]);
            end
            checks++;
            if (m_ready_g[g] !== 1'b1) begin
                errors++; $display("FAIL %s g%0d m_ready_end: got %b want 1", name, g, m_ready_g[g]);
            end
            checks++;
            if (rvalid_g[g] !== exp_rvalid) begin
                errors++; $display("FAIL %s g%0d rvalid: got %b want %b", name, g, rvalid_g[g], exp_rvalid);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lane(rdata_g[g], i) !== exp_rdata[i]) begin
                    errors++; $display("FAIL %s g%0d rdata%0d: got %0d want %0d", name, g, i, lane(rdata_g[g], i), exp_rdata[i]);
                end
            end
        end
    endtask

    task automatic reset_mid(input logic wr, input logic [63:0] b_addr, input logic [63:0] b_wd,
                             input int at_cyc, input string name);
        logic [15:0] a;
        @(negedge clk);
        m_read = !wr; m_write = wr; en = 4'hF; addr = b_addr; wdata = b_wd;
        @(negedge clk);
        m_read = 1'b0; m_write = 1'b0;
        for (int c = 0; c < at_cyc; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        if (wr) begin
            for (int i = 0; i < at_cyc; i++) begin
                a = lane(b_addr, i);
                ref_mem[a[7:0]] = lane(b_wd, i);
            end
        end
        exp_rvalid = 4'b0;
        for (int i = 0; i < 4; i++) exp_rdata[i] = 16'd0;
        check_idle_outputs(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_basic();
        run_batch(1'b0, 1'b1, 4'b1110, {16'd13, 16'd12, 16'd11, 16'd0}, {16'd24, 16'd55, 16'd20, 16'd0}, 1'b0, "preload_11_13");
        run_batch(1'b1, 1'b0, 4'b1110, {16'd13, 16'd12, 16'd11, 16'd0}, 64'd0, 1'b0, "read_basic");
    endtask

    task automatic test_write_readback();
        run_batch(1'b0, 1'b1, 4'b1011, {16'd43, 16'd0, 16'd41, 16'd40}, {16'd24, 16'd0, 16'd20, 16'd9}, 1'b0, "write_1011");
        run_batch(1'b1, 1'b0, 4'b1011, {16'd43, 16'd0, 16'd41, 16'd40}, 64'd0, 1'b0, "readback_1011");
    endtask

    task automatic test_coalesce();
        run_batch(1'b0, 1'b1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd7}, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, "preload_7");
        run_batch(1'b1, 1'b0, 4'b1111, {16'd7, 16'd7, 16'd7, 16'd7}, 64'd0, 1'b0, "coalesce_all7");
        run_batch(1'b1, 1'b0, 4'b1111, {16'd40, 16'd12, 16'd40, 16'd12}, 64'd0, 1'b0, "coalesce_pairs");
    endtask

    task automatic test_lat3();
        run_batch(1'b1, 1'b0, 4'b1111, {16'd43, 16'd13, 16'd12, 16'd11}, 64'd0, 1'b0, "lat3_distinct");
    endtask

    task automatic test_ignored();
        run_batch(1'b1, 1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, 64'd0, 1'b0, "read_en0");
        run_batch(1'b0, 1'b1, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "write_en0");
        run_batch(1'b1, 1'b1, 4'b1111, {16'd11, 16'd12, 16'd13, 16'd40}, 64'h1111_2222_3333_4444, 1'b0, "both_high");
        run_batch(1'b1, 1'b0, 4'b1111, {16'd11, 16'd12, 16'd13, 16'd40}, 64'd0, 1'b1, "start_while_busy");
    endtask

    task automatic test_reset_mid();
        reset_mid(1'b1, {16'd83, 16'd82, 16'd81, 16'd80}, {16'hD4, 16'hC3, 16'hB2, 16'hA1}, 2, "reset_mid_write");
        run_batch(1'b1, 1'b0, 4'b1111, {16'd83, 16'd82, 16'd81, 16'd80}, 64'd0, 1'b0, "after_reset_write");
        reset_mid(1'b0, {16'd83, 16'd82, 16'd81, 16'd80}, 64'd0, 2, "reset_mid_read");
        run_batch(1'b1, 1'b0, 4'b0110, {16'd0, 16'd81, 16'd80, 16'd0}, 64'd0, 1'b0, "after_reset_read");
    endtask

    task automatic test_random();
        logic        rd;
        logic        wr;
        logic [63:0] ra;
        logic [63:0] rw;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            for (int i = 0; i < 4; i++) begin
                ra[i*16 +: 16] = 16'(100 + $urandom_range(0, 5));
                rw[i*16 +: 16] = 16'($urandom_range(0, 65535));
            end
            run_batch(rd, wr, 4'($urandom_range(0, 15)), ra, rw, 1'b0, "random");
        end
    endtask

    initial begin
        reset = 1'b1; m_read = 1'b0; m_write = 1'b0; en = 4'b0; addr = 64'd0; wdata = 64'd0;
        mem_init = 1'b1;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        for (int i = 0; i < 4; i++) exp_rdata[i] = 16'd0;
        exp_rvalid = 4'b0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        #1;
        test_reset();
        test_read_basic();
        test_write_readback();
        test_coalesce();
        test_lat3();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
